// File: rtl/scandoubler_ce.sv
// scandoubler_ce: single-clock 15 kHz -> 31 kHz scan doubler with ping-pong line buffer and registered bypass.
// Optional feature macro SCANDBL_DIM_EN builds second-pass scanline dimming selected by scanline_mode.
module scandoubler_ce #(
    parameter int CW          = 3,
    parameter int ADDRW       = 10,
    parameter int MIN_LINE    = 128,
    parameter int HSYNC_LEN   = 96,
    parameter int VSYNC_LINES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce_pix,
    input  logic             enable_scandoubling,
    input  logic [1:0]       scanline_mode,
    input  logic [CW-1:0]    ri,
    input  logic [CW-1:0]    gi,
    input  logic [CW-1:0]    bi,
    input  logic             hsync_ext_n,
    input  logic             vsync_ext_n,
    output logic [CW-1:0]    ro,
    output logic [CW-1:0]    go,
    output logic [CW-1:0]    bo,
    output logic             hsync,
    output logic             vsync,
    output logic [ADDRW-1:0] line_len
);
    localparam logic [ADDRW-1:0] MIN_L = ADDRW'(MIN_LINE);
    localparam logic [ADDRW-1:0] HS_L  = ADDRW'(HSYNC_LEN);
    localparam logic [7:0]       VS_L  = 8'(VSYNC_LINES);

    logic [3*CW-1:0]  ram [2**(ADDRW+1)];
    logic [3*CW-1:0]  rdata;
    logic [ADDRW-1:0] waddr, raddr;
    logic             wbank, rbank, pass, idle, hs_prev, vs_prev, arm;
    logic [7:0]       vlines;
    logic             pass_d, idle_d, hs_d, vs_d;
    logic             hs_fall, vs_fall, line_switch, at_end, pass_start;
    logic [CW-1:0]    r_px, g_px, b_px;

    assign hs_fall     = ce_pix & hs_prev & ~hsync_ext_n;
    assign vs_fall     = ce_pix & vs_prev & ~vsync_ext_n;
    assign line_switch = hs_fall & (waddr >= MIN_L);
    assign at_end      = ~idle & (raddr == line_len - 1'b1);
    assign pass_start  = line_switch | (at_end & ~pass);

    // write side: capture source pixels, detect accepted hsync edges, swap banks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            waddr    <= '0;
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            line_len <= '0;
            hs_prev  <= 1'b1;
            vs_prev  <= 1'b1;
        end else if (ce_pix) begin
            hs_prev <= hsync_ext_n;
            vs_prev <= vsync_ext_n;
            if (line_switch) begin
                line_len <= waddr;
                rbank    <= wbank;
                wbank    <= ~wbank;
                waddr    <= '0;
            end else if (waddr != '1) begin
                waddr <= waddr + 1'b1;
            end
        end
    end

    // line buffer: write on pixel enable, registered read of the replay bank
    always_ff @(posedge clk) begin
        if (rst_n && ce_pix) ram[{wbank, waddr}] <= {ri, gi, bi};
        rdata <= ram[{rbank, raddr}];
    end

    // read side: two full-rate passes per captured line, then idle; vsync line counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raddr  <= '0;
            pass   <= 1'b1;
            idle   <= 1'b1;
            arm    <= 1'b0;
            vlines <= '0;
        end else begin
            if (line_switch) begin
                raddr <= '0;
                pass  <= 1'b0;
                idle  <= (waddr == '0);
            end else if (at_end) begin
                if (!pass) begin
                    raddr <= '0;
                    pass  <= 1'b1;
                end else begin
                    idle <= 1'b1;
                end
            end else if (!idle) begin
                raddr <= raddr + 1'b1;
            end
            arm <= vs_fall | (arm & ~pass_start);
            if (pass_start && arm) vlines <= VS_L;
            else if (pass_start && vlines != 8'd0) vlines <= vlines - 1'b1;
        end
    end

`ifdef SCANDBL_DIM_EN
    function automatic logic [CW-1:0] dim(input logic [CW-1:0] x, input logic [1:0] m);
        return m == 2'b01 ? x - (x >> 2) : m == 2'b10 ? x >> 1 : m == 2'b11 ? x >> 2 : x;
    endfunction

    // colour after blanking, dimmed on the second pass
    always_comb begin
        {r_px, g_px, b_px} = idle_d ? '0 : rdata;
        r_px = pass_d ? dim(r_px, scanline_mode) : r_px;
        g_px = pass_d ? dim(g_px, scanline_mode) : g_px;
        b_px = pass_d ? dim(b_px, scanline_mode) : b_px;
    end
`else
    logic unused_mode;
    assign unused_mode = ^{scanline_mode, pass_d};

    // colour after blanking; both passes identical
    always_comb begin
        {r_px, g_px, b_px} = idle_d ? '0 : rdata;
    end
`endif

    // output stage: align control with RAM read, select doubled or bypass path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass_d <= 1'b1;
            idle_d <= 1'b1;
            hs_d   <= 1'b0;
            vs_d   <= 1'b0;
            ro     <= '0;
            go     <= '0;
            bo     <= '0;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
        end else begin
            pass_d <= pass;
            idle_d <= idle;
            hs_d   <= ~idle & (raddr < HS_L);
            vs_d   <= (vlines != 8'd0);
            ro     <= enable_scandoubling ? r_px : ri;
            go     <= enable_scandoubling ? g_px : gi;
            bo     <= enable_scandoubling ? b_px : bi;
            hsync  <= enable_scandoubling ? ~hs_d : hsync_ext_n & vsync_ext_n;
            vsync  <= enable_scandoubling ? ~vs_d : 1'b1;
        end
    end
endmodule

// File: tb/tb_scandoubler_ce.sv
// tb_scandoubler_ce: directed bench for scandoubler_ce; honours SCANDBL_DIM_EN for expected dimming.
module tb_scandoubler_ce;
    logic       clk = 1'b0, rst_n = 1'b0, ce_pix = 1'b0, enable_scandoubling = 1'b1;
    logic [1:0] scanline_mode = 2'b00;
    logic [2:0] ri = 3'd0, gi = 3'd0, bi = 3'd0, ro, go, bo;
    logic       hsync_ext_n = 1'b1, vsync_ext_n = 1'b1, hsync, vsync;
    logic       vs_lvl = 1'b1, cap = 1'b0;
    logic [9:0] line_len;
    int         checks = 0, passes = 0;

    typedef struct packed {
        logic [8:0] c;
        logic       hs;
        logic       vs;
    } smp_t;
    smp_t q[$];
    int   f[$];

`ifdef SCANDBL_DIM_EN
    localparam logic [8:0] K1 = 9'o333, L1 = 9'o666, M1 = 9'o111;
`else
    localparam logic [8:0] K1 = 9'o777, L1 = 9'o777, M1 = 9'o777;
`endif

    scandoubler_ce dut (
        .clk(clk), .rst_n(rst_n), .ce_pix(ce_pix), .enable_scandoubling(enable_scandoubling),
        .scanline_mode(scanline_mode), .ri(ri), .gi(gi), .bi(bi),
        .hsync_ext_n(hsync_ext_n), .vsync_ext_n(vsync_ext_n),
        .ro(ro), .go(go), .bo(bo), .hsync(hsync), .vsync(vsync), .line_len(line_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cap) q.push_back({ro, go, bo, hsync, vsync});

    function automatic logic [8:0] pk(input int v);
        return {3'(v), 3'(v + 1), 3'(v + 2)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic pixel(input logic [8:0] c, input logic hs, input logic vs);
        {ri, gi, bi} = c;
        hsync_ext_n = hs;
        vsync_ext_n = vs;
        ce_pix = 1'b1;
        @(posedge clk); #1;
        ce_pix = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic feed_line(input int kind, input int n, input int glitch, input int vs_drop);
        for (int i = 0; i < n; i++) begin
            if (i == vs_drop) vs_lvl = 1'b0;
            pixel(kind == 2 ? 9'o777 : kind == 1 ? pk(7 - i) : pk(i), i != glitch, vs_lvl);
        end
        pixel(9'o0, 1'b0, vs_lvl);
    endtask

    task automatic check_pass(input string tag, input int s, input int kind, input int n, input logic [8:0] cst);
        int bc = 0, bh = 0;
        logic [8:0] e;
        for (int k = 0; k < n; k++) begin
            e = kind == 2 ? cst : kind == 1 ? pk(7 - k) : pk(k);
            if (q[s + k].c !== e) bc++;
            if (q[s + k].hs !== (k >= 96)) bh++;
        end
        chk({tag, " colour mismatches"}, bc, 0);
        chk({tag, " hsync mismatches"}, bh, 0);
    endtask

    task automatic check_blank(input string tag, input int a, input int b);
        int bad = 0;
        for (int j = a; j < b; j++) if (q[j].c !== 9'd0 || q[j].hs !== 1'b1) bad++;
        chk({tag, " non-blank samples"}, bad, 0);
    endtask

    initial begin
        pixel(pk(5), 1'b0, 1'b1);
        pixel(pk(6), 1'b1, 1'b1);
        @(negedge clk);
        chk("reset colour", {ro, go, bo}, 0);
        chk("reset hsync", hsync, 1);
        chk("reset vsync", vsync, 1);
        chk("reset line_len", line_len, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cap = 1'b1;
        feed_line(0, 200, -1, -1);
        chk("line_len A", line_len, 200);
        feed_line(1, 200, -1, -1);
        feed_line(0, 200, -1, -1);
        feed_line(0, 300, 50, -1);
        chk("line_len glitch line", line_len, 300);
        feed_line(1, 250, -1, -1);
        chk("line_len short line", line_len, 250);
        feed_line(0, 300, -1, 100);
        vs_lvl = 1'b1;
        feed_line(0, 200, -1, -1);
        feed_line(2, 200, -1, -1);
        scanline_mode = 2'b10;
        feed_line(2, 200, -1, -1);
        scanline_mode = 2'b01;
        feed_line(2, 200, -1, -1);
        scanline_mode = 2'b11;
        feed_line(2, 200, -1, -1);
        cap = 1'b0;
        for (int j = 1; j < q.size(); j++) if (q[j - 1].hs === 1'b1 && q[j].hs === 1'b0) f.push_back(j);
        chk("pass start count", f.size(), 20);
        if (f.size() >= 20) begin
            check_blank("before first line", 0, f[0]);
            check_pass("A p0", f[0], 0, 200, 9'd0);
            check_pass("A p1", f[1], 0, 200, 9'd0);
            chk("A pass gap", f[1] - f[0], 200);
            chk("A line gap", f[2] - f[1], 202);
            check_pass("B p0", f[2], 1, 200, 9'd0);
            check_pass("B p1", f[3], 1, 200, 9'd0);
            check_pass("C p0", f[4], 0, 200, 9'd0);
            check_pass("C p1", f[5], 0, 200, 9'd0);
            chk("C idle gap", f[6] - f[5], 402);
            check_blank("C idle", f[5] + 200, f[6]);
            check_pass("G p0", f[6], 0, 300, 9'd0);
            check_pass("G p1", f[7], 0, 200, 9'd0);
            check_pass("H p0", f[8], 1, 250, 9'd0);
            check_pass("H p1", f[9], 1, 250, 9'd0);
            chk("H pass gap", f[9] - f[8], 250);
            chk("H idle gap", f[10] - f[9], 352);
            check_blank("H idle", f[9] + 250, f[10]);
            check_pass("I p0", f[10], 0, 300, 9'd0);
            check_pass("K p0", f[14], 2, 200, 9'o777);
            check_pass("K p1 mode10", f[15], 2, 200, K1);
            check_pass("L p1 mode01", f[17], 2, 200, L1);
            check_pass("M p1 mode11", f[19], 2, 200, M1);
            begin
                int first_low = -1, last_low = -1, low_cnt = 0;
                for (int j = 0; j < q.size(); j++) begin
                    if (q[j].vs !== 1'b1) begin
                        if (first_low < 0) first_low = j;
                        last_low = j;
                        low_cnt++;
                    end
                end
                chk("vsync first low", first_low, f[9]);
                chk("vsync last low", last_low, f[11] - 1);
                chk("vsync low count", low_cnt, f[11] - f[9]);
            end
        end
        enable_scandoubling = 1'b0;
        {ri, gi, bi} = 9'o123;
        hsync_ext_n = 1'b1;
        vsync_ext_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bypass hsync", hsync, 0);
        chk("bypass vsync", vsync, 1);
        chk("bypass colour", {ro, go, bo}, 9'o123);
        @(posedge clk); #1;
        {ri, gi, bi} = 9'o456;
        vsync_ext_n = 1'b1;
        @(negedge clk);
        chk("bypass latency", {ro, go, bo}, 9'o123);
        @(posedge clk);
        @(negedge clk);
        chk("bypass colour 2", {ro, go, bo}, 9'o456);
        chk("bypass hsync high", hsync, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        enable_scandoubling = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("late reset line_len", line_len, 0);
        chk("late reset colour", {ro, go, bo}, 0);
        chk("late reset hsync", hsync, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
